// File: rtl/range_arb_pkg.sv
// Shared definitions for the range job arbiter.
// Holds the arbiter FSM state encoding, default WIDTH/NREQ/TIMEOUT values and
// an index-width helper used to size requester-index signals.
package range_arb_pkg;

    localparam int unsigned DEF_WIDTH   = 8;
    localparam int unsigned DEF_NREQ    = 4;
    localparam int unsigned DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DUP  = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    // Bits needed to hold a requester index; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection.
// Ports:
//   req        - request vector, one bit per requester
//   last_grant - index of the requester served most recently
//   grant      - one-hot winner; search starts at last_grant+1 and wraps, 0 if no request
module rr_arbiter
    import range_arb_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IDXW = idx_w(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_grant,
    output logic [NREQ-1:0] grant
);

    int unsigned idx;
    logic        found;

    // Scan NREQ positions starting one past the previous winner; first hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_grant) + k) % NREQ;
            if (!found && req[IDXW'(idx)]) begin
                grant[IDXW'(idx)] = 1'b1;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/range_job_arbiter.sv
// Range job arbiter: grants one requester at a time round-robin, streams its
// samples to a range datapath with first/final strobes, and returns the
// datapath result as a one-cycle, one-hot response.
// Optional feature: define RANGE_ARB_TIMEOUT_EN to add a stall-cycle timeout
// (TIMEOUT consecutive non-beat RUN cycles) that force-completes the job with
// rsp_error = 1. Without it, RUN waits indefinitely.
// Ports:
//   clock, reset            - rising-edge clock, async active-high reset
//   req_valid/data/last     - per-requester sample streams (data packed i*WIDTH)
//   req_ready               - beat acceptance, at most one bit set
//   rf_data/rf_go/rf_finish - sample and first/final strobes to the datapath
//   rf_range/rf_error       - datapath result and error inputs
//   rsp_valid/range/error   - registered job completion response
//   grant                   - one-hot owner of the current job, 0 when idle
module range_job_arbiter
    import range_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned NREQ    = DEF_NREQ,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      rf_data,
    output logic                  rf_go,
    output logic                  rf_finish,
    input  logic [WIDTH-1:0]      rf_range,
    input  logic                  rf_error,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_range,
    output logic                  rsp_error,
    output logic [NREQ-1:0]       grant
);

    localparam int unsigned IDXW = idx_w(NREQ);

    arb_state_e       state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [IDXW-1:0]  last_grant_q, last_grant_d;
    logic             first_q, first_d;
    logic [WIDTH-1:0] held_q, held_d;
    logic             job_err_q, job_err_d;
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_range_q, rsp_range_d;
    logic             rsp_error_q, rsp_error_d;

    logic [NREQ-1:0]  rr_grant;
    logic             g_valid;
    logic             g_last;
    logic [WIDTH-1:0] g_data;
    logic [IDXW-1:0]  grant_idx;

`ifdef RANGE_ARB_TIMEOUT_EN
    localparam int unsigned SW = idx_w(TIMEOUT + 1);
    logic [SW-1:0] stall_q, stall_d;
`else
    localparam int unsigned TIMEOUT_UNUSED = TIMEOUT;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (rr_grant)
    );

    // Mux the granted requester's signals; grant_q is one-hot or zero.
    always_comb begin
        g_valid   = |(req_valid & grant_q);
        g_last    = |(req_last & grant_q);
        g_data    = '0;
        grant_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                g_data    = g_data | req_data[i*WIDTH +: WIDTH];
                grant_idx = IDXW'(i);
            end
        end
    end

    // Next-state and datapath/handshake outputs.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        first_d      = first_q;
        held_d       = held_q;
        job_err_d    = job_err_q;
        rsp_valid_d  = '0;
        rsp_range_d  = rsp_range_q;
        rsp_error_d  = rsp_error_q;
        req_ready    = '0;
        rf_data      = held_q;
        rf_go        = 1'b0;
        rf_finish    = 1'b0;
`ifdef RANGE_ARB_TIMEOUT_EN
        stall_d      = stall_q;
`endif

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d   = rr_grant;
                    first_d   = 1'b1;
                    job_err_d = 1'b0;
`ifdef RANGE_ARB_TIMEOUT_EN
                    stall_d   = '0;
`endif
                    state_d   = RUN;
                end
            end

            RUN: begin
                job_err_d = job_err_q | rf_error;
`ifdef RANGE_ARB_TIMEOUT_EN
                if (stall_q == SW'(TIMEOUT)) begin
                    // Forced completion; no strobe at all if nothing was ever sent.
                    rf_finish   = !first_q;
                    rsp_range_d = first_q ? '0 : rf_range;
                    rsp_error_d = 1'b1;
                    rsp_valid_d = grant_q;
                    state_d     = RESP;
                end else begin
`endif
                    req_ready = req_valid & grant_q;
                    if (g_valid) begin
                        rf_data = g_data;
                        held_d  = g_data;
`ifdef RANGE_ARB_TIMEOUT_EN
                        stall_d = '0;
`endif
                        if (first_q) begin
                            // A single-sample job gets its finish strobe from DUP.
                            rf_go   = 1'b1;
                            first_d = 1'b0;
                            if (g_last) begin
                                state_d = DUP;
                            end
                        end else if (g_last) begin
                            rf_finish   = 1'b1;
                            rsp_range_d = rf_range;
                            rsp_error_d = job_err_q | rf_error;
                            rsp_valid_d = grant_q;
                            state_d     = RESP;
                        end
                    end
`ifdef RANGE_ARB_TIMEOUT_EN
                    else begin
                        stall_d = stall_q + SW'(1);
                    end
                end
`endif
            end

            DUP: begin
                job_err_d   = job_err_q | rf_error;
                rf_finish   = 1'b1;
                rsp_range_d = rf_range;
                rsp_error_d = job_err_q | rf_error;
                rsp_valid_d = grant_q;
                state_d     = RESP;
            end

            RESP: begin
                last_grant_d = grant_idx;
                grant_d      = '0;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset leaves requester 0 as the first round-robin winner.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDXW'(NREQ - 1);
            first_q      <= 1'b0;
            held_q       <= '0;
            job_err_q    <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_range_q  <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            first_q      <= first_d;
            held_q       <= held_d;
            job_err_q    <= job_err_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_range_q  <= rsp_range_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

`ifdef RANGE_ARB_TIMEOUT_EN
    // Consecutive non-beat RUN cycle counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_range = rsp_range_q;
    assign rsp_error = rsp_error_q;
    assign grant     = grant_q;

endmodule
